io_write_arbiter: RTL and testbench
===================================

# io_write_arbiter

Shares the memory-mapped IO write path between two requesters: port 0 is the CPU store path and port 1 is the debug/loader port. The block accepts one write at a time through a valid/ready handshake and latches its address and data. It then drives a single-cycle registered write strobe toward the IO device registers, which are decoded by one-hot word-address bits with the LEDs at bit 0. A programmable settle gap follows every strobe. Writes to word address 0, which selects no device, are acknowledged and dropped, and each one is counted.

## Interface
- SETTLE_CYCLES, default 1: idle cycles held after each strobe before the next grant; legal range 0..15.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- req0_valid  input  1  CPU write request; held with addr/wdata until ready.
- req0_addr  input  32  CPU byte address.
- req0_wdata  input  32  CPU write data.
- req0_ready  output  1  CPU request accepted this cycle.
- req1_valid  input  1  debug write request; same rules as port 0.
- req1_addr  input  32  debug byte address.
- req1_wdata  input  32  debug write data.
- req1_ready  output  1  debug request accepted this cycle.
- io_en  output  1  one-cycle write strobe to IO devices.
- io_addr  output  32  latched address; valid while io_en.
- io_wdata  output  32  latched data; valid while io_en.
- grant_id  output  1  requester that owns the current or last transaction.
- busy  output  1  high in any state other than IDLE.
- drop_count  output  8  saturating count of dropped null writes.

## Operation
- The FSM has three states: IDLE, STROBE and SETTLE.
- In IDLE with any valid request:
  - Select a winner and assert that port's ready combinationally in the same cycle.
  - Latch the winner's addr, wdata and grant_id.
  - Go to STROBE.
- STROBE:
  - Normal write: io_en=1 for exactly one cycle.
  - Null write (latched addr[31:2]==0): io_en stays 0 and drop_count increments, saturating at 255.
  - Next state is SETTLE if SETTLE_CYCLES>0, otherwise IDLE.
- SETTLE: a 4-bit counter counts SETTLE_CYCLES cycles, then returns to IDLE.
- Ready is never asserted outside IDLE. At most one ready is asserted per cycle.
- A requester that is not granted keeps valid high; the block never drops a pending request.
- io_addr and io_wdata hold their latched values until the next acceptance. They are don't-care when io_en=0.
- Arbitration policy is set by the Configuration macro.

## Timing
- Reset values:
  - State IDLE.
  - io_en=0, io_addr=0, io_wdata=0.
  - grant_id=0, busy=0, drop_count=0.
  - Both ready outputs are 0 during reset.
  - Internal last_grant=1, so port 0 wins the first tie.
- Acceptance happens in cycle N, with ready high in N. io_en is high in N+1. The first possible next acceptance is N+2+SETTLE_CYCLES.
- Throughput is one write per 2+SETTLE_CYCLES cycles.
- Simultaneous valids in IDLE: exactly one port is granted; the other waits at least until the next IDLE.
- Reset asserted in STROBE or SETTLE: the next cycle is IDLE with io_en=0. The aborted strobe is not re-issued. drop_count clears.
- A valid that drops before ready is not a protocol error and has no effect.

## Configuration
- IO_WRITE_ARB_RR_EN defined: round-robin arbitration.
  - On a tie the winner is the port that is not last_grant.
  - last_grant updates on every acceptance.
- IO_WRITE_ARB_RR_EN undefined: fixed priority, with port 0 always winning a tie.
  - last_grant is not implemented, and grant_id still reports the winner.

## Test plan
- Single write, SETTLE_CYCLES=1:
  - Stimulus: req0 with addr=0x4, wdata=0x15.
  - Required: req0_ready high in cycle N; io_en high in N+1 with io_addr=0x4 and io_wdata=0x15; busy high in N+1..N+2; IDLE at N+3.
- Null write:
  - Stimulus: req1 with addr=0x0.
  - Required: req1_ready pulses, io_en stays 0, drop_count becomes 1.
  - Then: 300 further null writes leave drop_count at 255.
- Tie, round-robin enabled:
  - Stimulus: both ports held valid continuously.
  - Required: grants alternate 0,1,0,1 starting with port 0; each port sees ready exactly once per 2×(2+SETTLE_CYCLES) cycles.
- Tie, macro undefined:
  - Stimulus: both ports held valid continuously.
  - Required: port 0 granted every transaction while it stays valid; port 1 granted only after req0_valid drops.
- Reset mid-operation:
  - Stimulus: reset asserted in the STROBE cycle.
  - Required: io_en is 0 the following cycle, busy=0, and no second strobe occurs for that request.
- SETTLE_CYCLES=0:
  - Stimulus: back-to-back req0 writes.
  - Required: io_en high every other cycle, ready on the alternate cycles.

Source files
------------

// File: rtl/io_write_arbiter.sv
// Two-port arbiter for the memory-mapped IO write path: CPU (port 0) and debug/loader (port 1).
// Define IO_WRITE_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module io_write_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        io_en,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic        grant_id,
    output logic        busy,
    output logic [7:0]  drop_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    localparam logic [3:0] LP_SETTLE_LAST =
        (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    logic [1:0]  r_state;
    logic [3:0]  r_settle_cnt;
    logic        r_io_en;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_wdata;
    logic        r_grant_id;
    logic        r_null;
    logic [7:0]  r_drop_count;
`ifdef IO_WRITE_ARB_RR_EN
    logic        r_last_grant;
`endif

    logic        w_idle;
    logic        w_pick0;
    logic        w_pick1;
    logic        w_accept;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_null;

    // Ready is withheld during reset so no request is consumed by a reset cycle.
    assign w_idle = (r_state == ST_IDLE) && !reset;

`ifdef IO_WRITE_ARB_RR_EN
    assign w_pick1 = req1_valid && (!req0_valid || !r_last_grant);
`else
    assign w_pick1 = req1_valid && !req0_valid;
`endif
    assign w_pick0 = req0_valid && !w_pick1;

    assign w_accept    = w_idle && (w_pick0 || w_pick1);
    assign w_sel_addr  = w_pick1 ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_pick1 ? req1_wdata : req0_wdata;
    assign w_sel_null  = (w_sel_addr[31:2] == 30'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_io_en      <= 1'b0;
            r_io_addr    <= '0;
            r_io_wdata   <= '0;
            r_grant_id   <= 1'b0;
            r_null       <= 1'b0;
            r_drop_count <= '0;
`ifdef IO_WRITE_ARB_RR_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_io_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_io_addr  <= w_sel_addr;
                        r_io_wdata <= w_sel_wdata;
                        r_grant_id <= w_pick1;
                        r_null     <= w_sel_null;
                        // Strobe is registered here so it appears exactly in the STROBE cycle.
                        r_io_en    <= !w_sel_null;
`ifdef IO_WRITE_ARB_RR_EN
                        r_last_grant <= w_pick1;
`endif
                        r_state    <= ST_STROBE;
                    end
                end
                ST_STROBE: begin
                    if (r_null && (r_drop_count != 8'hFF)) begin
                        r_drop_count <= r_drop_count + 8'd1;
                    end
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle_cnt <= LP_SETTLE_LAST;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready = w_idle && w_pick0;
    assign req1_ready = w_idle && w_pick1;
    assign io_en      = r_io_en;
    assign io_addr    = r_io_addr;
    assign io_wdata   = r_io_wdata;
    assign grant_id   = r_grant_id;
    assign busy       = (r_state != ST_IDLE);
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Directed bench for io_write_arbiter: instance a uses SETTLE_CYCLES=1, instance b uses 0.
// Tie expectations follow IO_WRITE_ARB_RR_EN.
module tb_io_write_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
    logic [31:0] a_req0_addr, a_req0_wdata, a_req1_addr, a_req1_wdata;
    logic        a_io_en, a_grant_id, a_busy;
    logic [31:0] a_io_addr, a_io_wdata;
    logic [7:0]  a_drop_count;

    logic        b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [31:0] b_req0_addr, b_req0_wdata, b_req1_addr, b_req1_wdata;
    logic        b_io_en, b_grant_id, b_busy;
    logic [31:0] b_io_addr, b_io_wdata;
    logic [7:0]  b_drop_count;

    io_write_arbiter #(.SETTLE_CYCLES(1)) u_dut_a (
        .clk(clk), .reset(reset),
        .req0_valid(a_req0_valid), .req0_addr(a_req0_addr), .req0_wdata(a_req0_wdata), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_addr(a_req1_addr), .req1_wdata(a_req1_wdata), .req1_ready(a_req1_ready),
        .io_en(a_io_en), .io_addr(a_io_addr), .io_wdata(a_io_wdata),
        .grant_id(a_grant_id), .busy(a_busy), .drop_count(a_drop_count)
    );

    io_write_arbiter #(.SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata), .req1_ready(b_req1_ready),
        .io_en(b_io_en), .io_addr(b_io_addr), .io_wdata(b_io_wdata),
        .grant_id(b_grant_id), .busy(b_busy), .drop_count(b_drop_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at posedge+2, outputs are sampled at posedge+3.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int grants;
        int last_acc;
        int strobes;
        logic got1;
        logic exp_grant;

        reset = 1'b1;
        a_req0_valid = 1'b1; a_req0_addr = 32'h4; a_req0_wdata = 32'h15;
        a_req1_valid = 1'b0; a_req1_addr = '0;    a_req1_wdata = '0;
        b_req0_valid = 1'b0; b_req0_addr = '0;    b_req0_wdata = '0;
        b_req1_valid = 1'b0; b_req1_addr = '0;    b_req1_wdata = '0;

        cyc(); cyc(); #1;
        check("rst_ready0", a_req0_ready, 1'b0);
        check("rst_io_en", a_io_en, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_drop", a_drop_count, 8'd0);
        check("rst_io_addr", a_io_addr, 32'h0);
        check("rst_io_wdata", a_io_wdata, 32'h0);
        check("rst_grant", a_grant_id, 1'b0);

        // Single write, cycle N
        cyc(); reset = 1'b0; #1;
        check("wr_ready0_N", a_req0_ready, 1'b1);
        check("wr_ready1_N", a_req1_ready, 1'b0);
        cyc(); a_req0_valid = 1'b0; #1;
        check("wr_io_en_N1", a_io_en, 1'b1);
        check("wr_io_addr", a_io_addr, 32'h4);
        check("wr_io_wdata", a_io_wdata, 32'h15);
        check("wr_busy_N1", a_busy, 1'b1);
        check("wr_ready0_N1", a_req0_ready, 1'b0);
        cyc(); #1;
        check("wr_io_en_N2", a_io_en, 1'b0);
        check("wr_busy_N2", a_busy, 1'b1);
        cyc(); #1;
        check("wr_busy_N3", a_busy, 1'b0);

        // Null write from port 1
        cyc(); a_req1_valid = 1'b1; a_req1_addr = 32'h0; a_req1_wdata = 32'hDEAD; #1;
        check("null_ready1", a_req1_ready, 1'b1);
        check("null_ready0", a_req0_ready, 1'b0);
        cyc(); a_req1_valid = 1'b0; #1;
        check("null_io_en", a_io_en, 1'b0);
        check("null_busy", a_busy, 1'b1);
        check("null_grant", a_grant_id, 1'b1);
        cyc(); #1;
        check("null_drop1", a_drop_count, 8'd1);

        // 300 further null writes saturate the counter
        cyc(); a_req1_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 1200; i++) begin
            #1;
            if (a_req1_ready) n++;
            if (n == 300) break;
            cyc();
        end
        check("sat_accepts", n, 300);
        cyc(); a_req1_valid = 1'b0;
        cyc(); cyc(); cyc(); #1;
        check("sat_drop", a_drop_count, 8'd255);
        check("sat_busy", a_busy, 1'b0);

        // Tie: both ports held valid
        cyc();
        a_req0_valid = 1'b1; a_req0_addr = 32'h10; a_req0_wdata = 32'hA0;
        a_req1_valid = 1'b1; a_req1_addr = 32'h20; a_req1_wdata = 32'hB0;
        grants = 0;
        last_acc = 0;
        exp_grant = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("tie_onehot", a_req0_ready & a_req1_ready, 1'b0);
            if (a_req0_ready || a_req1_ready) begin
`ifdef IO_WRITE_ARB_RR_EN
                exp_grant = 1'(grants % 2);
`else
                exp_grant = 1'b0;
`endif
                check("tie_grant", a_req1_ready, exp_grant);
                if (grants > 0) check("tie_spacing", i - last_acc, 3);
                last_acc = i;
                grants++;
            end
            if (grants == 6) break;
            cyc();
        end
        check("tie_count", grants, 6);
        cyc(); a_req0_valid = 1'b0; #1;
        check("tie_last_io_en", a_io_en, 1'b1);
        check("tie_last_addr", a_io_addr, exp_grant ? 32'h20 : 32'h10);
        got1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            if (a_req1_ready) begin
                got1 = 1'b1;
                break;
            end
        end
        check("tie_port1_after_drop", got1, 1'b1);
        cyc(); a_req1_valid = 1'b0; #1;
        check("tie_port1_strobe", a_io_addr, 32'h20);
        cyc(); cyc();

        // Reset asserted during STROBE
        cyc(); a_req0_valid = 1'b1; a_req0_addr = 32'h8; a_req0_wdata = 32'h77; #1;
        check("rmo_ready0", a_req0_ready, 1'b1);
        cyc(); a_req0_valid = 1'b0; reset = 1'b1; #1;
        check("rmo_strobe", a_io_en, 1'b1);
        cyc(); reset = 1'b0; #1;
        check("rmo_io_en_after", a_io_en, 1'b0);
        check("rmo_busy_after", a_busy, 1'b0);
        check("rmo_drop_clear", a_drop_count, 8'd0);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(); #1;
            if (a_io_en) strobes++;
        end
        check("rmo_no_restrobe", strobes, 0);

        // SETTLE_CYCLES=0: back-to-back writes on instance b
        cyc(); b_req0_valid = 1'b1; b_req0_addr = 32'h4;
        for (int i = 0; i < 8; i++) begin
            b_req0_wdata = 32'(i / 2 + 1);
            #1;
            check("s0_ready", b_req0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            check("s0_io_en", b_io_en, (i % 2 == 1) ? 1'b1 : 1'b0);
            if (i % 2 == 1) check("s0_wdata", b_io_wdata, 32'(i / 2 + 1));
            cyc();
        end
        b_req0_valid = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
